gf_2to128_digit_serial_multiplier: RTL

GF_2TO128_DIGIT_SERIAL_MULTIPLIER -- requirements
Module: gf_2to128_digit_serial_multiplier

---
 rtl/gf_2to128_digit_serial_multiplier.sv | 102 ++++++++++
 1 files changed

// File: rtl/gf_2to128_digit_serial_multiplier.sv
// Digit-serial GF(2^128) multiplier (GCM polynomial), NB_DIGIT bits of X per clock.
// Optional GF_MULT_BIT_REFLECT_EN: bit-reverse operands/result at the ports.
module gf_2to128_digit_serial_multiplier #(
  parameter int NB_DATA  = 128,
  parameter int NB_DIGIT = 8
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_data_x,
  input  logic [NB_DATA-1:0] i_data_y,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data_z
);

  localparam bit BAD_CONF = (NB_DATA != 128) ||
                            !((NB_DIGIT == 1)  || (NB_DIGIT == 2)  || (NB_DIGIT == 4)  ||
                              (NB_DIGIT == 8)  || (NB_DIGIT == 16) || (NB_DIGIT == 32) ||
                              (NB_DIGIT == 64) || (NB_DIGIT == 128));

  localparam int N      = NB_DATA / NB_DIGIT;
  localparam int NB_CNT = $clog2(N) + 1;
  localparam logic [NB_CNT-1:0]  CNT_LAST = NB_CNT'(N - 1);
  localparam logic [NB_DATA-1:0] R_POLY   = {8'he1, {(NB_DATA-8){1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [NB_CNT-1:0]  r_cnt;
  logic [NB_DATA-1:0] r_x;
  logic [NB_DATA-1:0] r_v;
  logic [NB_DATA-1:0] r_z;
  logic [NB_DATA-1:0] w_x_in;
  logic [NB_DATA-1:0] w_y_in;
  logic [NB_DATA-1:0] w_z_nxt;
  logic [NB_DATA-1:0] w_v_nxt;

  if (BAD_CONF) begin : g_bad_conf
  end

`ifdef GF_MULT_BIT_REFLECT_EN
  assign w_x_in   = {<<{i_data_x}};
  assign w_y_in   = {<<{i_data_y}};
  assign o_data_z = {<<{r_z}};
`else
  assign w_x_in   = i_data_x;
  assign w_y_in   = i_data_y;
  assign o_data_z = r_z;
`endif

  assign o_ready = (r_state == ST_IDLE);
  assign o_valid = (r_state == ST_DONE);

  // One digit of the bit-serial GCM algorithm, unrolled; r_x is kept left-aligned.
  always_comb begin
    w_z_nxt = r_z;
    w_v_nxt = r_v;
    for (int unsigned i = 0; i < NB_DIGIT; i++) begin
      if (r_x[NB_DATA-1-i]) w_z_nxt = w_z_nxt ^ w_v_nxt;
      if (w_v_nxt[0]) w_v_nxt = (w_v_nxt >> 1) ^ R_POLY;
      else            w_v_nxt = w_v_nxt >> 1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_v     <= '0;
      r_z     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_x     <= w_x_in;
            r_v     <= w_y_in;
            r_z     <= '0;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_z   <= w_z_nxt;
          r_v   <= w_v_nxt;
          r_x   <= r_x << NB_DIGIT;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (i_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
